// File: rtl/sound_pkg.sv
// sound_pkg: shared constants and types for the DAC feeder (sound_sender).
//   FRAME_W / SAMPLE_W : widths of a stereo frame and one channel sample
//   byte_ptr_e         : position of the next byte within a frame
//   frame_t            : stereo frame layout, {R, L}
//   LOAD_PERIOD        : clocks between DAC load pulses (one channel word each)
package sound_pkg;

  localparam int FRAME_W     = 32;
  localparam int SAMPLE_W    = 16;
  localparam int LOAD_PERIOD = 320;

  typedef enum logic [1:0] {
    BP_LLO = 2'd0,
    BP_LHI = 2'd1,
    BP_RLO = 2'd2,
    BP_RHI = 2'd3
  } byte_ptr_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] r;
    logic [SAMPLE_W-1:0] l;
  } frame_t;

endpackage

// File: rtl/sound_fifo.sv
// sound_fifo: generic synchronous FIFO, occupancy tracked by a counter.
//   clock, reset : system clock, synchronous active-high reset (control only)
//   push, push_data : write request and data; accepted when not full, or when
//                     full and a pop is accepted in the same cycle
//   pop, pop_data   : read request; pop_data always shows the head entry
//                     (first-word fall-through); ignored when empty
//   full, empty, level : occupancy status
// There is no bypass: a pop on an empty FIFO is ignored even if a push lands
// in the same cycle.
module sound_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign pop_ok   = pop && !empty;
  // A full FIFO can still take a push when the same cycle frees a slot.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage is data only; stale contents are unreachable after reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sound_sender.sv
// sound_sender: feeds the serial DAC stage with stereo 16-bit words.
//   clock, reset     : 24 MHz system clock, synchronous active-high reset
//   wr_stb, wr_data  : byte stream L_lo, L_hi, R_lo, R_hi
//   byte_sync        : realigns the byte pointer to L_lo
//   load, dac_leftright : DAC latch pulse and channel just latched
//   datain           : registered word to the DAC, changes only at load+2
//   fifo_level/full/empty : frame FIFO occupancy
//   overflow, underrun : sticky error flags, cleared by flag_clr
module sound_sender
  import sound_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_stb,
  input  logic [7:0]             wr_data,
  input  logic                   byte_sync,
  input  logic                   load,
  input  logic                   dac_leftright,
  output logic [SAMPLE_W-1:0]    datain,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow,
  output logic                   underrun,
  input  logic                   flag_clr
);

  // Offset-binary input is converted to two's complement by flipping the MSB.
  function automatic logic [SAMPLE_W-1:0] to_dac_code(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] r;
    r = s;
    if (!SIGNED_IN) r[SAMPLE_W-1] = ~s[SAMPLE_W-1];
    return r;
  endfunction

  byte_ptr_e        byte_ptr;
  byte_ptr_e        byte_idx;
  logic [7:0]       l_lo;
  logic [7:0]       l_hi;
  logic [7:0]       r_lo;
  frame_t           wr_frame;
  logic             frame_done;
  logic             drop;
  logic             pop_req;
  logic             pop_empty;
  logic [FRAME_W-1:0] pop_word;

  frame_t           frame_p1;
  logic             lr_p1;
  logic             vld_p1;

  always_comb begin
    // byte_sync forces a same-cycle byte into the L_lo slot.
    byte_idx   = byte_sync ? BP_LLO : byte_ptr;
    frame_done = wr_stb && (byte_idx == BP_RHI);
    wr_frame   = '{r: {wr_data, r_lo}, l: {l_hi, l_lo}};
    // After R has been latched the DAC needs the L word of the next frame.
    pop_req    = load && dac_leftright;
    pop_empty  = pop_req && fifo_empty;
    // A pop in the same cycle frees a slot, so only then is a full FIFO safe.
    drop       = frame_done && fifo_full && !pop_req;
  end

  sound_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (frame_done),
    .push_data (wr_frame),
    .pop       (pop_req),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Byte assembler: pointer wraps 3 -> 0, even when the frame is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_ptr <= BP_LLO;
    end else if (wr_stb) begin
      byte_ptr <= byte_ptr_e'(byte_idx + 2'd1);
    end else if (byte_sync) begin
      byte_ptr <= BP_LLO;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_stb) begin
      case (byte_idx)
        BP_LLO:  l_lo <= wr_data;
        BP_LHI:  l_hi <= wr_data;
        BP_RLO:  r_lo <= wr_data;
        default: ;
      endcase
    end
  end

  // Sticky flags: a set event beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (drop)          overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
      if (pop_empty)     underrun <= 1'b1;
      else if (flag_clr) underrun <= 1'b0;
    end
  end

  // ---- stage p1: capture popped frame and channel at the load edge ----
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_p1 <= '0;
      lr_p1    <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= load;
      if (load)    lr_p1    <= dac_leftright;
      if (pop_req) frame_p1 <= fifo_empty ? '0 : frame_t'(pop_word);
    end
  end

  // ---- stage p2: select the next channel word for the DAC ----
  // lr_p1 = 1 means R was just latched, so L is the next word out.
  always_ff @(posedge clock) begin
    if (reset) begin
      datain <= '0;
    end else if (vld_p1) begin
      datain <= to_dac_code(lr_p1 ? frame_p1.l : frame_p1.r);
    end
  end

endmodule

// File: tb/tb_sound_sender.sv
module tb_sound_sender;
  import sound_pkg::*;

  localparam int GAP = LOAD_PERIOD - 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic        byte_sync;
  logic        load;
  logic        dac_leftright;
  logic        flag_clr;

  logic [15:0] datain,    u_datain;
  logic [4:0]  fifo_level, u_level;
  logic        fifo_full, u_full;
  logic        fifo_empty, u_empty;
  logic        overflow, u_overflow;
  logic        underrun, u_underrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] d, du;

  always #5 clock = ~clock;

  sound_sender #(.DEPTH(16), .SIGNED_IN(1'b1)) dut (
    .clock(clock), .reset(reset), .wr_stb(wr_stb), .wr_data(wr_data),
    .byte_sync(byte_sync), .load(load), .dac_leftright(dac_leftright),
    .datain(datain), .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .overflow(overflow), .underrun(underrun),
    .flag_clr(flag_clr)
  );

  sound_sender #(.DEPTH(16), .SIGNED_IN(1'b0)) dut_u (
    .clock(clock), .reset(reset), .wr_stb(wr_stb), .wr_data(wr_data),
    .byte_sync(byte_sync), .load(load), .dac_leftright(dac_leftright),
    .datain(u_datain), .fifo_level(u_level), .fifo_full(u_full),
    .fifo_empty(u_empty), .overflow(u_overflow), .underrun(u_underrun),
    .flag_clr(flag_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_stb = 1'b1;
    wr_data = b;
    step();
    wr_stb = 1'b0;
  endtask

  task automatic write_frame(input logic [15:0] l, input logic [15:0] r);
    write_byte(l[7:0]);
    write_byte(l[15:8]);
    write_byte(r[7:0]);
    write_byte(r[15:8]);
  endtask

  // One DAC load; returns datain of both DUTs at load+2, then idles a period.
  task automatic dac_load(input logic lr, output logic [15:0] d2, output logic [15:0] d2u);
    logic [15:0] prev;
    prev = datain;
    load = 1'b1;
    dac_leftright = lr;
    step();
    load = 1'b0;
    dac_leftright = 1'b0;
    chk("hold_at_load1", datain, prev);
    step();
    d2 = datain;
    d2u = u_datain;
    repeat (GAP) step();
  endtask

  initial begin
    reset = 1'b1; wr_stb = 1'b0; wr_data = 8'h00; byte_sync = 1'b0;
    load = 1'b0; dac_leftright = 1'b0; flag_clr = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_datain", datain, 16'h0000);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_u_datain", u_datain, 16'h0000);
    chk("rst_u_level", u_level, 5'd0);
    chk("rst_u_flags", {u_full, u_empty, u_overflow, u_underrun}, 4'b0100);

    // Loads on an empty FIFO
    dac_load(1'b1, d, du);
    chk("ur_datain_l", d, 16'h0000);
    chk("ur_flag", underrun, 1'b1);
    dac_load(1'b0, d, du);
    chk("ur_datain_r", d, 16'h0000);
    chk("ur_empty", fifo_empty, 1'b1);
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    chk("ur_clear", underrun, 1'b0);

    // Basic frame
    write_frame(16'h1234, 16'h5678);
    chk("basic_level", fifo_level, 5'd1);
    chk("basic_empty", fifo_empty, 1'b0);
    dac_load(1'b1, d, du);
    chk("basic_l", d, 16'h1234);
    chk("basic_level0", fifo_level, 5'd0);
    dac_load(1'b0, d, du);
    chk("basic_r", d, 16'h5678);
    chk("basic_no_ur", underrun, 1'b0);

    // Offset-binary conversion
    write_frame(16'h8000, 16'h0001);
    dac_load(1'b1, d, du);
    chk("sgn_l", d, 16'h8000);
    chk("ofs_l", du, 16'h0000);
    dac_load(1'b0, d, du);
    chk("sgn_r", d, 16'h0001);
    chk("ofs_r", du, 16'h8001);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < 16; i++) write_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    chk("fill_full", fifo_full, 1'b1);
    chk("fill_level", fifo_level, 5'd16);
    chk("fill_no_ovf", overflow, 1'b0);
    write_frame(16'hDEAD, 16'hBEEF);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_level", fifo_level, 5'd16);
    chk("ovf_full", fifo_full, 1'b1);
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    chk("ovf_clear", overflow, 1'b0);

    // Full FIFO: frame completes on the same cycle as an lr=1 load
    write_byte(8'h33); write_byte(8'h33); write_byte(8'h44);
    wr_stb = 1'b1; wr_data = 8'h44; load = 1'b1; dac_leftright = 1'b1;
    step();
    wr_stb = 1'b0; load = 1'b0; dac_leftright = 1'b0;
    chk("simul_level", fifo_level, 5'd16);
    chk("simul_no_ovf", overflow, 1'b0);
    chk("simul_full", fifo_full, 1'b1);
    step();
    chk("simul_l0", datain, 16'h1000);
    repeat (GAP) step();
    dac_load(1'b0, d, du);
    chk("simul_r0", d, 16'h2000);
    for (int i = 1; i < 16; i++) begin
      dac_load(1'b1, d, du);
      chk("drain_l", d, 16'h1000 + 16'(i));
      dac_load(1'b0, d, du);
      chk("drain_r", d, 16'h2000 + 16'(i));
    end
    dac_load(1'b1, d, du);
    chk("drain_last_l", d, 16'h3333);
    dac_load(1'b0, d, du);
    chk("drain_last_r", d, 16'h4444);
    chk("drain_level", fifo_level, 5'd0);
    chk("drain_empty", fifo_empty, 1'b1);
    chk("drain_no_ur", underrun, 1'b0);

    // byte_sync realignment
    write_byte(8'hAA); write_byte(8'hBB);
    wr_stb = 1'b1; byte_sync = 1'b1; wr_data = 8'h11;
    step();
    wr_stb = 1'b0; byte_sync = 1'b0;
    write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    chk("sync_level", fifo_level, 5'd1);
    dac_load(1'b1, d, du);
    chk("sync_l", d, 16'h2211);
    dac_load(1'b0, d, du);
    chk("sync_r", d, 16'h4433);

    // Reset mid-frame with a frame queued
    write_frame(16'h5555, 16'h6666);
    write_byte(8'h77); write_byte(8'h88);
    chk("pre_rst_level", fifo_level, 5'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_level", fifo_level, 5'd0);
    chk("mid_rst_datain", datain, 16'h0000);
    chk("mid_rst_empty", fifo_empty, 1'b1);
    write_frame(16'h0201, 16'h0403);
    chk("post_rst_level", fifo_level, 5'd1);
    dac_load(1'b1, d, du);
    chk("post_rst_l", d, 16'h0201);
    dac_load(1'b0, d, du);
    chk("post_rst_r", d, 16'h0403);

    // Push into empty FIFO concurrent with a pop: no bypass
    write_byte(8'h21); write_byte(8'h43); write_byte(8'h65);
    wr_stb = 1'b1; wr_data = 8'h87; load = 1'b1; dac_leftright = 1'b1;
    step();
    wr_stb = 1'b0; load = 1'b0; dac_leftright = 1'b0;
    chk("nobyp_underrun", underrun, 1'b1);
    chk("nobyp_level", fifo_level, 5'd1);
    step();
    chk("nobyp_l_zero", datain, 16'h0000);
    repeat (GAP) step();
    dac_load(1'b0, d, du);
    chk("nobyp_r_zero", d, 16'h0000);
    dac_load(1'b1, d, du);
    chk("nobyp_l", d, 16'h4321);
    chk("nobyp_level0", fifo_level, 5'd0);
    dac_load(1'b0, d, du);
    chk("nobyp_r", d, 16'h8765);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
